ctrl_pipeline: RTL

- Downstream consumer of the decoder's control outputs in the 5-stage RV32I pipeline (D -> E -> M -> W).
- Registers control and register-index fields through the E, M and W stages.
- Detects load-use hazards and generates stall and flush signals.
- Resolves branch/jump redirect in E and drives the E-stage forwarding-mux selects.

---
 rtl/ctrl_pipeline.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipeline.sv
// Control/index staging for the E, M and W stages, with load-use stall, redirect flush and forwarding selects.
// Optional performance counters are built in when CTRL_PIPE_PERF_EN is defined.
module ctrl_pipeline #(
  parameter int RF_AW  = 5,
  parameter int ALUC_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ValidD,
  input  logic              RegWriteD,
  input  logic              MemWriteD,
  input  logic              BranchD,
  input  logic              JumpD,
  input  logic              ALUSrcD,
  input  logic [1:0]        ResultSrcD,
  input  logic [ALUC_W-1:0] ALUControlD,
  input  logic [RF_AW-1:0]  Rs1D,
  input  logic [RF_AW-1:0]  Rs2D,
  input  logic [RF_AW-1:0]  RdD,
  input  logic              ZeroE,
  output logic              StallF,
  output logic              StallD,
  output logic              FlushD,
  output logic              PCSrcE,
  output logic              RegWriteE,
  output logic              RegWriteM,
  output logic              RegWriteW,
  output logic              MemWriteE,
  output logic              MemWriteM,
  output logic              ALUSrcE,
  output logic [1:0]        ResultSrcE,
  output logic [1:0]        ResultSrcM,
  output logic [1:0]        ResultSrcW,
  output logic [ALUC_W-1:0] ALUControlE,
  output logic [RF_AW-1:0]  Rs1E,
  output logic [RF_AW-1:0]  Rs2E,
  output logic [RF_AW-1:0]  RdE,
  output logic [RF_AW-1:0]  RdM,
  output logic [RF_AW-1:0]  RdW,
  output logic [1:0]        ForwardAE,
  output logic [1:0]        ForwardBE,
  output logic              ValidW
`ifdef CTRL_PIPE_PERF_EN
  ,
  output logic [31:0]       RetireCnt,
  output logic [31:0]       StallCnt,
  output logic [31:0]       FlushCnt
`endif
);

  logic valid_e;
  logic branch_e;
  logic jump_e;
  logic valid_m;
  logic lw_stall;
  logic flush_e;

  // Hazard detection and redirect, all combinational on the current E/D contents.
  always_comb begin
    lw_stall = 1'b0;
    PCSrcE   = 1'b0;
    if (valid_e && (ResultSrcE == 2'b01) && (RdE != '0) &&
        ((Rs1D == RdE) || (Rs2D == RdE)))
      lw_stall = 1'b1;
    if (valid_e && ((branch_e && ZeroE) || jump_e))
      PCSrcE = 1'b1;
  end

  // A redirect discards the D instruction, so it overrides the stall.
  assign StallF  = lw_stall & ~PCSrcE;
  assign StallD  = lw_stall & ~PCSrcE;
  assign FlushD  = PCSrcE;
  assign flush_e = lw_stall | PCSrcE;

  // M has priority over W; x0 is never a forwarding source.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (RdM != '0) && (RdM == Rs1E))
      ForwardAE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs1E))
      ForwardAE = 2'b01;
    if (RegWriteM && (RdM != '0) && (RdM == Rs2E))
      ForwardBE = 2'b10;
    else if (RegWriteW && (RdW != '0) && (RdW == Rs2E))
      ForwardBE = 2'b01;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e     <= 1'b0;
      branch_e    <= 1'b0;
      jump_e      <= 1'b0;
      RegWriteE   <= 1'b0;
      MemWriteE   <= 1'b0;
      ALUSrcE     <= 1'b0;
      ResultSrcE  <= 2'b00;
      ALUControlE <= '0;
      Rs1E        <= '0;
      Rs2E        <= '0;
      RdE         <= '0;
      valid_m     <= 1'b0;
      RegWriteM   <= 1'b0;
      MemWriteM   <= 1'b0;
      ResultSrcM  <= 2'b00;
      RdM         <= '0;
      ValidW      <= 1'b0;
      RegWriteW   <= 1'b0;
      ResultSrcW  <= 2'b00;
      RdW         <= '0;
    end else begin
      if (flush_e) begin
        valid_e     <= 1'b0;
        branch_e    <= 1'b0;
        jump_e      <= 1'b0;
        RegWriteE   <= 1'b0;
        MemWriteE   <= 1'b0;
        ALUSrcE     <= 1'b0;
        ResultSrcE  <= 2'b00;
        ALUControlE <= '0;
        Rs1E        <= '0;
        Rs2E        <= '0;
        RdE         <= '0;
      end else begin
        valid_e     <= ValidD;
        branch_e    <= BranchD;
        jump_e      <= JumpD;
        RegWriteE   <= RegWriteD;
        MemWriteE   <= MemWriteD;
        ALUSrcE     <= ALUSrcD;
        ResultSrcE  <= ResultSrcD;
        ALUControlE <= ALUControlD;
        Rs1E        <= Rs1D;
        Rs2E        <= Rs2D;
        RdE         <= RdD;
      end
      valid_m    <= valid_e;
      RegWriteM  <= RegWriteE;
      MemWriteM  <= MemWriteE;
      ResultSrcM <= ResultSrcE;
      RdM        <= RdE;
      ValidW     <= valid_m;
      RegWriteW  <= RegWriteM;
      ResultSrcW <= ResultSrcM;
      RdW        <= RdM;
    end
  end

`ifdef CTRL_PIPE_PERF_EN
  // Free-running event counters; they wrap naturally at 32 bits.
  always_ff @(posedge clk) begin
    if (rst) begin
      RetireCnt <= '0;
      StallCnt  <= '0;
      FlushCnt  <= '0;
    end else begin
      if (ValidW) RetireCnt <= RetireCnt + 32'd1;
      if (StallD) StallCnt  <= StallCnt + 32'd1;
      if (PCSrcE) FlushCnt  <= FlushCnt + 32'd1;
    end
  end
`endif

endmodule
